// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - return address stack with per-prediction checkpoint restore
//
// Purpose:
//   Fetch0 return address stack. A BTB hit with RAS control applies a
//   speculative push / pop / pop+push in fetch order. The current top is
//   presented combinationally as the predicted return target. Every cycle the
//   pre-op {cnt,tos} and top entry are exported as a checkpoint, which travels
//   with the branch and is handed back on a redirect to restore the stack.
//
// Configuration macro:
//   RAS_REPAIR_TOP_EN - when defined, a redirect also rewrites the entry at the
//                       restored tos with redirect_top_i, repairing a top entry
//                       clobbered by wrong-path pushes. When undefined only the
//                       pointer and count are restored and redirect_top_i is
//                       ignored.
//
// Ports:
//   clock            in   core clock, all state updates on posedge
//   reset            in   synchronous active-high reset (beats redirect_i)
//   ras_hit_i        in   BTB hit at f0; ops ignored when low
//   ras_ctl_i        in   00 none, 01 push, 10 pop, 11 pop+push
//   ras_push_addr_i  in   return address to push
//   fetch_stall_i    in   f0 stalled; op not applied
//   redirect_i       in   restore {cnt,tos} from redirect_ckpt_i; drops any op
//   redirect_ckpt_i  in   checkpoint {cnt,tos}
//   redirect_top_i   in   saved top entry (repair build only)
//   ras_tar_o        out  predicted return target, entry[tos] or 0 if empty
//   ras_valid_o      out  cnt != 0
//   ras_ckpt_o       out  {cnt,tos} before this cycle's op
//   ras_ckpt_top_o   out  entry[tos] before this cycle's op

module ras_stack #(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int ADDR_W = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ras_hit_i,
  input  logic [1:0]           ras_ctl_i,
  input  logic [ADDR_W-1:0]    ras_push_addr_i,
  input  logic                 fetch_stall_i,
  input  logic                 redirect_i,
  input  logic [2*PTR_W:0]     redirect_ckpt_i,
  input  logic [ADDR_W-1:0]    redirect_top_i,
  output logic [ADDR_W-1:0]    ras_tar_o,
  output logic                 ras_valid_o,
  output logic [2*PTR_W:0]     ras_ckpt_o,
  output logic [ADDR_W-1:0]    ras_ckpt_top_o
);

  localparam logic [1:0] CTL_NONE    = 2'b00;
  localparam logic [1:0] CTL_PUSH    = 2'b01;
  localparam logic [1:0] CTL_POP     = 2'b10;
  localparam logic [1:0] CTL_POPPUSH = 2'b11;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [ADDR_W-1:0] entry [DEPTH];
  logic [PTR_W-1:0]  tos;
  logic [PTR_W:0]    cnt;

  logic [PTR_W-1:0]  tos_nxt;
  logic [PTR_W:0]    cnt_nxt;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] wr_data;

  logic              op_en;
  logic              cnt_zero;
  logic              cnt_full;
  logic [PTR_W:0]    ckpt_cnt;
  logic [PTR_W-1:0]  ckpt_tos;
  logic [ADDR_W-1:0] top_entry;

  assign ckpt_cnt = redirect_ckpt_i[2*PTR_W:PTR_W];
  assign ckpt_tos = redirect_ckpt_i[PTR_W-1:0];

  // Redirect outranks any op presented in the same cycle.
  assign op_en    = ras_hit_i & ~fetch_stall_i & ~redirect_i;
  assign cnt_zero = (cnt == '0);
  assign cnt_full = (cnt == CNT_FULL);

`ifndef RAS_REPAIR_TOP_EN
  logic unused_redirect_top;
  assign unused_redirect_top = ^redirect_top_i;
`endif

  always_comb begin
    tos_nxt = tos;
    cnt_nxt = cnt;
    wr_en   = 1'b0;
    wr_idx  = tos;
    wr_data = ras_push_addr_i;
    if (redirect_i) begin
      tos_nxt = ckpt_tos;
      cnt_nxt = ckpt_cnt;
`ifdef RAS_REPAIR_TOP_EN
      wr_en   = 1'b1;
      wr_idx  = ckpt_tos;
      wr_data = redirect_top_i;
`endif
    end else if (op_en) begin
      case (ras_ctl_i)
        CTL_PUSH: begin
          // Circular buffer: when full, the new top lands on the oldest slot.
          tos_nxt = tos + PTR_ONE;
          wr_en   = 1'b1;
          wr_idx  = tos + PTR_ONE;
          cnt_nxt = cnt_full ? cnt : cnt + CNT_ONE;
        end
        CTL_POP: begin
          if (!cnt_zero) begin
            tos_nxt = tos - PTR_ONE;
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        CTL_POPPUSH: begin
          // Replace the top in place; an empty stack gains its first entry.
          wr_en   = 1'b1;
          wr_idx  = tos;
          if (cnt_zero) cnt_nxt = CNT_ONE;
        end
        CTL_NONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tos <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
    end else begin
      tos <= tos_nxt;
      cnt <= cnt_nxt;
      if (wr_en) entry[wr_idx] <= wr_data;
    end
  end

  // Reads come only from registered state, so a push is visible next cycle.
  assign top_entry      = entry[tos];
  assign ras_tar_o      = cnt_zero ? '0 : top_entry;
  assign ras_valid_o    = ~cnt_zero;
  assign ras_ckpt_o     = {cnt, tos};
  assign ras_ckpt_top_o = top_entry;

endmodule

// File: tb/tb_ras_stack.sv
// tb/tb_ras_stack.sv - scoreboard bench for ras_stack

module tb_ras_stack;

  logic        clock;
  logic        reset;
  logic        ras_hit_i;
  logic [1:0]  ras_ctl_i;
  logic [63:0] ras_push_addr_i;
  logic        fetch_stall_i;
  logic        redirect_i;
  logic [8:0]  redirect_ckpt_i;
  logic [63:0] redirect_top_i;
  logic [63:0] ras_tar_o;
  logic        ras_valid_o;
  logic [8:0]  ras_ckpt_o;
  logic [63:0] ras_ckpt_top_o;

  ras_stack #(.DEPTH(16), .PTR_W(4), .ADDR_W(64)) dut (
    .clock           (clock),
    .reset           (reset),
    .ras_hit_i       (ras_hit_i),
    .ras_ctl_i       (ras_ctl_i),
    .ras_push_addr_i (ras_push_addr_i),
    .fetch_stall_i   (fetch_stall_i),
    .redirect_i      (redirect_i),
    .redirect_ckpt_i (redirect_ckpt_i),
    .redirect_top_i  (redirect_top_i),
    .ras_tar_o       (ras_tar_o),
    .ras_valid_o     (ras_valid_o),
    .ras_ckpt_o      (ras_ckpt_o),
    .ras_ckpt_top_o  (ras_ckpt_top_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        v;
    logic [63:0] tar;
    logic [8:0]  ck;
    logic        chk_top;
    logic [63:0] top;
  } exp_t;

  exp_t exp_q[$];
  logic sample_req = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

`ifdef RAS_REPAIR_TOP_EN
  localparam bit REPAIR = 1'b1;
`else
  localparam bit REPAIR = 1'b0;
`endif

  function automatic logic [8:0] ck(input int c, input int t);
    return {c[4:0], t[3:0]};
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops one expectation whenever the stimulus flags a sample point.
  always @(negedge clock) begin
    if (sample_req) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_empty: got no expectation expected one queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp({e.name, ".valid"}, {63'd0, ras_valid_o}, {63'd0, e.v});
        cmp({e.name, ".tar"},   ras_tar_o,            e.tar);
        cmp({e.name, ".ckpt"},  {55'd0, ras_ckpt_o},  {55'd0, e.ck});
        if (e.chk_top) cmp({e.name, ".top"}, ras_ckpt_top_o, e.top);
      end
    end
  end

  task automatic idle_inputs();
    ras_hit_i       = 1'b0;
    ras_ctl_i       = 2'b00;
    ras_push_addr_i = '0;
    fetch_stall_i   = 1'b0;
    redirect_i      = 1'b0;
    redirect_ckpt_i = '0;
    redirect_top_i  = '0;
  endtask

  task automatic op(input logic hit, input logic [1:0] ctl, input logic [63:0] addr,
                    input logic stall, input logic redir, input logic [8:0] ckp,
                    input logic [63:0] top);
    ras_hit_i       = hit;
    ras_ctl_i       = ctl;
    ras_push_addr_i = addr;
    fetch_stall_i   = stall;
    redirect_i      = redir;
    redirect_ckpt_i = ckp;
    redirect_top_i  = top;
    @(posedge clock);
    #1;
    idle_inputs();
  endtask

  task automatic push(input logic [63:0] a);    op(1, 2'b01, a, 0, 0, '0, '0); endtask
  task automatic pop();                         op(1, 2'b10, '0, 0, 0, '0, '0); endtask
  task automatic poppush(input logic [63:0] a); op(1, 2'b11, a, 0, 0, '0, '0); endtask
  task automatic redirect(input logic [8:0] c, input logic [63:0] t); op(0, 2'b00, '0, 0, 1, c, t); endtask

  task automatic expect_st(input string name, input logic v, input logic [63:0] tar,
                           input logic [8:0] ckv, input logic chk_top, input logic [63:0] top);
    exp_t e;
    e.name = name; e.v = v; e.tar = tar; e.ck = ckv; e.chk_top = chk_top; e.top = top;
    exp_q.push_back(e);
    sample_req = 1'b1;
    @(negedge clock);
    #1;
    sample_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] x;
    idle_inputs();
    // Reset held together with a redirect: reset must win.
    reset           = 1'b1;
    redirect_i      = 1'b1;
    redirect_ckpt_i = ck(3, 5);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    idle_inputs();
    expect_st("reset", 0, 64'h0, ck(0, 0), 1, 64'h0);

    // 1: pop on empty stack, and an op without a hit
    pop();
    expect_st("pop_empty", 0, 64'h0, ck(0, 0), 1, 64'h0);
    op(0, 2'b01, 64'h55, 0, 0, '0, '0);
    expect_st("no_hit", 0, 64'h0, ck(0, 0), 1, 64'h0);

    // 2: three pushes then pops
    push(64'h1000); expect_st("push1", 1, 64'h1000, ck(1, 1), 1, 64'h1000);
    push(64'h2000); expect_st("push2", 1, 64'h2000, ck(2, 2), 1, 64'h2000);
    push(64'h3000); expect_st("push3", 1, 64'h3000, ck(3, 3), 1, 64'h3000);
    pop(); expect_st("pop1", 1, 64'h2000, ck(2, 2), 0, '0);
    pop(); expect_st("pop2", 1, 64'h1000, ck(1, 1), 0, '0);
    pop(); expect_st("pop3", 0, 64'h0, ck(0, 0), 0, '0);

    // 3: overflow with 17 pushes, then 17 pops
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      push(64'(k * 'h100));
      expect_st($sformatf("ovf_push%0d", k), 1, 64'(k * 'h100), ck(k > 16 ? 16 : k, k % 16), 0, '0);
    end
    for (int i = 1; i <= 16; i++) begin
      pop();
      if (i < 16)
        expect_st($sformatf("ovf_pop%0d", i), 1, 64'('h1100 - i * 'h100), ck(16 - i, (1 - i) & 15), 0, '0);
      else
        expect_st("ovf_pop16", 0, 64'h0, ck(0, 1), 0, '0);
    end
    pop();
    expect_st("ovf_pop17", 0, 64'h0, ck(0, 1), 0, '0);

    // 4: wrong-path ops then redirect to saved checkpoint
    do_reset();
    push(64'hA0); expect_st("ckpt_a0", 1, 64'hA0, ck(1, 1), 1, 64'hA0);
    push(64'hB0); expect_st("wp_push", 1, 64'hB0, ck(2, 2), 0, '0);
    pop();        expect_st("wp_pop1", 1, 64'hA0, ck(1, 1), 0, '0);
    pop();        expect_st("wp_pop2", 0, 64'h0, ck(0, 0), 0, '0);
    redirect(ck(1, 1), 64'hA0);
    expect_st("redir1", 1, 64'hA0, ck(1, 1), 0, '0);
    poppush(64'hC0); expect_st("wp_poppush", 1, 64'hC0, ck(1, 1), 0, '0);
    redirect(ck(1, 1), 64'hA0);
    x = REPAIR ? 64'hA0 : 64'hC0;
    expect_st("redir2", 1, x, ck(1, 1), 1, x);

    // 5: stalled push holds state; push during redirect is dropped
    op(1, 2'b01, 64'h40, 1, 0, '0, '0);
    expect_st("stall", 1, x, ck(1, 1), 1, x);
    op(1, 2'b01, 64'h40, 0, 1, ck(3, 5), 64'h77);
    expect_st("redir_drop", 1, REPAIR ? 64'h77 : 64'h0, ck(3, 5), 0, '0);
    redirect(ck(1, 2), 64'h66);
    expect_st("drop_entry2", 1, REPAIR ? 64'h66 : 64'hB0, ck(1, 2), 0, '0);

    // 6: pop+push replaces the top in place
    do_reset();
    push(64'h70); push(64'h80);
    expect_st("pp_setup", 1, 64'h80, ck(2, 2), 0, '0);
    poppush(64'h90); expect_st("poppush", 1, 64'h90, ck(2, 2), 1, 64'h90);
    pop();           expect_st("pp_pop", 1, 64'h70, ck(1, 1), 0, '0);
    do_reset();
    poppush(64'hD0); expect_st("poppush_empty", 1, 64'hD0, ck(1, 0), 0, '0);

    repeat (2) @(posedge clock);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
